// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing decoder.
//   vga_lock_state_e : lock FSM states (SEARCH -> MEASURE -> LOCKED)
//   vga_total()      : full period of one axis (visible + front porch + pulse + back porch)
package vga_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } vga_lock_state_e;

    function automatic int vga_total(input int vis, input int fp, input int pulse, input int bp);
        return vis + fp + pulse + bp;
    endfunction

endpackage

// File: rtl/vga_axis_tracker.sv
// One timing axis of the VGA decoder (used once for lines, once for frames).
// The phase counter restarts on a rising edge of the active-high sync level and
// otherwise counts up, saturating at the expected period.
//   CLK, RST_N   : clock, asynchronous active-low reset
//   advance      : step strobe (every pixel for horizontal, every hs_rise for vertical)
//   sync_act     : sync level, already converted to active-high
//   total, pulse : expected period and sync pulse width
//   rise_chk_en  : enables the period check on the sync rising edge
//   phase        : current phase (0 in the cycle the sync rises)
//   start        : sync rising edge seen on an advance strobe
//   err          : any timing violation on this axis in this cycle
module vga_axis_tracker
    import vga_pkg::*;
#(
    parameter int PH_W = 10
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            advance,
    input  logic            sync_act,
    input  logic [PH_W-1:0] total,
    input  logic [PH_W-1:0] pulse,
    input  logic            rise_chk_en,
    output logic [PH_W-1:0] phase,
    output logic            start,
    output logic            err
);

    logic [PH_W-1:0] phase_p1;
    logic            act_p1;
    logic            fall;

    always_comb begin
        start = advance & sync_act & ~act_p1;
        fall  = advance & ~sync_act & act_p1;
        phase = phase_p1;
        if (advance) begin
            if (start) begin
                phase = '0;
            end else if (phase_p1 != total) begin
                phase = phase_p1 + 1'b1;
            end
        end
        // The registered phase still holds the last count of the previous period
        // when the new sync edge arrives; timeout fires only on reaching the limit.
        err = (start & rise_chk_en & (phase_p1 != total - 1'b1))
            | (fall & (phase != pulse))
            | ((phase == total) & (phase_p1 != total));
    end

    // stage p0 -> p1: phase and previous sync level
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase_p1 <= '0;
            act_p1   <= 1'b0;
        end else begin
            phase_p1 <= phase;
            if (advance) begin
                act_p1 <= sync_act;
            end
        end
    end

endmodule

// File: rtl/vga_timing_decoder.sv
// Receiving end of the VGA interface: recovers pixel coordinates and colour from
// raw h_sync/v_sync/RGB, tracks lock to the nominal timing and flags violations.
//   CLK, RST_N             : pixel clock, asynchronous active-low reset
//   vga_h_sync, vga_v_sync : raw-polarity sync inputs
//   vga_R/G/B              : 4-bit colour inputs
//   pix_valid, pix_x/y     : visible pixel strobe and coordinates (only while locked)
//   pix_r/g/b              : registered colour, 0 outside valid pixels
//   frame_start            : pulse on every vsync start
//   locked                 : timing matches the parameters
//   timing_err             : pulse when a violation drops the lock
module vga_timing_decoder
    import vga_pkg::*;
#(
    parameter int WIDTH              = 640,
    parameter int HSYNC_FPORCH       = 16,
    parameter int HSYNC_PULSE        = 96,
    parameter int HSYNC_BPORCH       = 48,
    parameter int HEIGHT             = 480,
    parameter int VSYNC_FPORCH       = 10,
    parameter int VSYNC_PULSE        = 2,
    parameter int VSYNC_BPORCH       = 33,
    parameter int HSYNC_POLARITY_NEG = 1,
    parameter int VSYNC_POLARITY_NEG = 1,
    parameter int H_CNT_WID          = $clog2(WIDTH),
    parameter int V_CNT_WID          = $clog2(HEIGHT),
    parameter int LOCK_FRAMES        = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 vga_h_sync,
    input  logic                 vga_v_sync,
    input  logic [3:0]           vga_R,
    input  logic [3:0]           vga_G,
    input  logic [3:0]           vga_B,
    output logic                 pix_valid,
    output logic [H_CNT_WID-1:0] pix_x,
    output logic [V_CNT_WID-1:0] pix_y,
    output logic [3:0]           pix_r,
    output logic [3:0]           pix_g,
    output logic [3:0]           pix_b,
    output logic                 frame_start,
    output logic                 locked,
    output logic                 timing_err
);

    localparam int H_TOTAL = vga_total(WIDTH, HSYNC_FPORCH, HSYNC_PULSE, HSYNC_BPORCH);
    localparam int V_TOTAL = vga_total(HEIGHT, VSYNC_FPORCH, VSYNC_PULSE, VSYNC_BPORCH);
    localparam int H_PH_W  = $clog2(H_TOTAL + 1);
    localparam int V_PH_W  = $clog2(V_TOTAL + 1);
    localparam int GOOD_W  = $clog2(LOCK_FRAMES + 1);

    localparam logic [H_PH_W-1:0] H_VIS_LO = H_PH_W'(HSYNC_PULSE + HSYNC_BPORCH);
    localparam logic [H_PH_W-1:0] H_VIS_HI = H_PH_W'(HSYNC_PULSE + HSYNC_BPORCH + WIDTH - 1);
    localparam logic [V_PH_W-1:0] V_VIS_LO = V_PH_W'(VSYNC_PULSE + VSYNC_BPORCH);
    localparam logic [V_PH_W-1:0] V_VIS_HI = V_PH_W'(VSYNC_PULSE + VSYNC_BPORCH + HEIGHT - 1);
    localparam logic HS_NEG = logic'(HSYNC_POLARITY_NEG != 0);
    localparam logic VS_NEG = logic'(VSYNC_POLARITY_NEG != 0);

    logic              hs_act, vs_act;
    logic [H_PH_W-1:0] h_phase;
    logic [V_PH_W-1:0] v_phase;
    logic              hs_rise, vs_start, h_err, v_err, err_any;

    vga_lock_state_e   state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d, good_inc;
    logic              first_line_q, first_line_d;
    logic              terr_d;

    logic                 vld_p0;
    logic [H_CNT_WID-1:0] x_p0;
    logic [V_CNT_WID-1:0] y_p0;

    assign hs_act = vga_h_sync ^ HS_NEG;
    assign vs_act = vga_v_sync ^ VS_NEG;

    // The first line after entering MEASURE may be a partial one, so its length is not judged.
    vga_axis_tracker #(.PH_W(H_PH_W)) u_h_axis (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .advance     (1'b1),
        .sync_act    (hs_act),
        .total       (H_PH_W'(H_TOTAL)),
        .pulse       (H_PH_W'(HSYNC_PULSE)),
        .rise_chk_en (~first_line_q),
        .phase       (h_phase),
        .start       (hs_rise),
        .err         (h_err)
    );

    vga_axis_tracker #(.PH_W(V_PH_W)) u_v_axis (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .advance     (hs_rise),
        .sync_act    (vs_act),
        .total       (V_PH_W'(V_TOTAL)),
        .pulse       (V_PH_W'(VSYNC_PULSE)),
        .rise_chk_en (1'b1),
        .phase       (v_phase),
        .start       (vs_start),
        .err         (v_err)
    );

    assign err_any  = h_err | v_err;
    assign good_inc = good_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        good_d       = good_q;
        first_line_d = first_line_q;
        terr_d       = 1'b0;
        case (state_q)
            SEARCH: begin
                if (vs_start) begin
                    state_d      = MEASURE;
                    good_d       = '0;
                    first_line_d = 1'b1;
                end
            end
            MEASURE: begin
                if (hs_rise) begin
                    first_line_d = 1'b0;
                end
                if (err_any) begin
                    good_d = '0;
                end else if (vs_start) begin
                    good_d = good_inc;
                    if (good_inc == GOOD_W'(LOCK_FRAMES)) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (err_any) begin
                    state_d = SEARCH;
                    terr_d  = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign vld_p0 = (state_q == LOCKED) & ~err_any
                  & (h_phase >= H_VIS_LO) & (h_phase <= H_VIS_HI)
                  & (v_phase >= V_VIS_LO) & (v_phase <= V_VIS_HI);
    assign x_p0   = H_CNT_WID'(h_phase - H_VIS_LO);
    assign y_p0   = V_CNT_WID'(v_phase - V_VIS_LO);

    // stage p0 -> p1: lock FSM and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= SEARCH;
            good_q       <= '0;
            first_line_q <= 1'b0;
            pix_valid    <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_r        <= '0;
            pix_g        <= '0;
            pix_b        <= '0;
            frame_start  <= 1'b0;
            locked       <= 1'b0;
            timing_err   <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_q       <= good_d;
            first_line_q <= first_line_d;
            pix_valid    <= vld_p0;
            pix_x        <= vld_p0 ? x_p0 : '0;
            pix_y        <= vld_p0 ? y_p0 : '0;
            pix_r        <= vld_p0 ? vga_R : 4'h0;
            pix_g        <= vld_p0 ? vga_G : 4'h0;
            pix_b        <= vld_p0 ? vga_B : 4'h0;
            frame_start  <= vs_start;
            locked       <= (state_d == LOCKED);
            timing_err   <= terr_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Bench for vga_timing_decoder on a shrunken raster (25 clocks x 11 lines).
// Three instances: negative-polarity (main), positive-polarity fed positive pulses,
// and positive-polarity fed negative pulses (must never lock).
module tb_vga_timing_decoder;

    localparam int W = 16, HFP = 2, HP = 4, HBP = 3;
    localparam int HT = W + HFP + HP + HBP;
    localparam int H = 6, VFP = 1, VP = 2, VBP = 2;
    localparam int VT = H + VFP + VP + VBP;
    localparam int XW = $clog2(W), YW = $clog2(H);
    localparam int X0 = HP + HBP, Y0 = VP + VBP;
    localparam int FAULT_LINE = 5;

    typedef struct {
        logic          fs, vld, lck, terr;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [3:0]    r, g, b;
    } exp_t;

    typedef struct {
        string name;
        int    n_lines;
        int    flen;
        int    fpw;
        int    err_line;
        int    err_off;
    } vec_t;

    logic CLK = 1'b0;
    logic RST_N;
    logic hs_raw, vs_raw, hs_pos, vs_pos;
    logic [3:0] r_in, g_in, b_in;

    logic pix_valid, frame_start, locked, timing_err;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [3:0] pix_r, pix_g, pix_b;

    logic p_valid, p_fs, p_locked, p_terr;
    logic [XW-1:0] p_x;
    logic [YW-1:0] p_y;
    logic [3:0] p_r, p_g, p_b;

    logic n_valid, n_fs, n_locked, n_terr;
    logic [XW-1:0] n_x;
    logic [YW-1:0] n_y;
    logic [3:0] n_r, n_g, n_b;

    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;
    int cnt = 0;
    int pend_eo = -1;
    vec_t tbl[6];

    always #5 CLK = ~CLK;

    vga_timing_decoder #(
        .WIDTH(W), .HSYNC_FPORCH(HFP), .HSYNC_PULSE(HP), .HSYNC_BPORCH(HBP),
        .HEIGHT(H), .VSYNC_FPORCH(VFP), .VSYNC_PULSE(VP), .VSYNC_BPORCH(VBP),
        .HSYNC_POLARITY_NEG(1), .VSYNC_POLARITY_NEG(1), .LOCK_FRAMES(2)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .vga_h_sync(hs_raw), .vga_v_sync(vs_raw),
        .vga_R(r_in), .vga_G(g_in), .vga_B(b_in),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_start(frame_start), .locked(locked), .timing_err(timing_err)
    );

    vga_timing_decoder #(
        .WIDTH(W), .HSYNC_FPORCH(HFP), .HSYNC_PULSE(HP), .HSYNC_BPORCH(HBP),
        .HEIGHT(H), .VSYNC_FPORCH(VFP), .VSYNC_PULSE(VP), .VSYNC_BPORCH(VBP),
        .HSYNC_POLARITY_NEG(0), .VSYNC_POLARITY_NEG(0), .LOCK_FRAMES(2)
    ) dut_pos (
        .CLK(CLK), .RST_N(RST_N), .vga_h_sync(hs_pos), .vga_v_sync(vs_pos),
        .vga_R(r_in), .vga_G(g_in), .vga_B(b_in),
        .pix_valid(p_valid), .pix_x(p_x), .pix_y(p_y),
        .pix_r(p_r), .pix_g(p_g), .pix_b(p_b),
        .frame_start(p_fs), .locked(p_locked), .timing_err(p_terr)
    );

    vga_timing_decoder #(
        .WIDTH(W), .HSYNC_FPORCH(HFP), .HSYNC_PULSE(HP), .HSYNC_BPORCH(HBP),
        .HEIGHT(H), .VSYNC_FPORCH(VFP), .VSYNC_PULSE(VP), .VSYNC_BPORCH(VBP),
        .HSYNC_POLARITY_NEG(0), .VSYNC_POLARITY_NEG(0), .LOCK_FRAMES(2)
    ) dut_inv (
        .CLK(CLK), .RST_N(RST_N), .vga_h_sync(hs_raw), .vga_v_sync(vs_raw),
        .vga_R(r_in), .vga_G(g_in), .vga_B(b_in),
        .pix_valid(n_valid), .pix_x(n_x), .pix_y(n_y),
        .pix_r(n_r), .pix_g(n_g), .pix_b(n_b),
        .frame_start(n_fs), .locked(n_locked), .timing_err(n_terr)
    );

    function automatic exp_t zero_exp();
        exp_t e;
        e.fs = 1'b0; e.vld = 1'b0; e.lck = 1'b0; e.terr = 1'b0;
        e.x = '0; e.y = '0; e.r = '0; e.g = '0; e.b = '0;
        return e;
    endfunction

    task automatic check_vec(input exp_t e, input string tag);
        logic ok_main, ok_pos, ok_inv;
        n_vec++;
        ok_main = (pix_valid === e.vld) && (frame_start === e.fs) && (locked === e.lck)
               && (timing_err === e.terr) && (pix_r === e.r) && (pix_g === e.g) && (pix_b === e.b)
               && (!e.vld || ((pix_x === e.x) && (pix_y === e.y)));
        ok_pos  = (p_valid === e.vld) && (p_fs === e.fs) && (p_locked === e.lck)
               && (p_terr === e.terr) && (p_r === e.r) && (p_g === e.g) && (p_b === e.b)
               && (!e.vld || ((p_x === e.x) && (p_y === e.y)));
        ok_inv  = (n_locked === 1'b0) && (n_valid === 1'b0) && (n_terr === 1'b0);
        if (!(ok_main && ok_pos && ok_inv)) begin
            n_bad++;
            $display("FAIL %s t=%0t actual: vld=%b x=%0d y=%0d rgb=%h%h%h fs=%b lock=%b terr=%b pos[vld/fs/lock/terr]=%b%b%b%b inv[lock/vld/terr]=%b%b%b required: vld=%b x=%0d y=%0d rgb=%h%h%h fs=%b lock=%b terr=%b inv_lock=0",
                     tag, $time, pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start, locked,
                     timing_err, p_valid, p_fs, p_locked, p_terr, n_locked, n_valid, n_terr,
                     e.vld, e.x, e.y, e.r, e.g, e.b, e.fs, e.lck, e.terr);
        end
    endtask

    // Drive one cycle, push its expectation, and compare once the registered outputs appear.
    task automatic step(input logic hs_a, input logic vs_a, input logic [3:0] cr,
                        input logic [3:0] cg, input logic [3:0] cb, input exp_t e,
                        input string tag);
        exp_t got;
        hs_raw = ~hs_a;
        vs_raw = ~vs_a;
        hs_pos = hs_a;
        vs_pos = vs_a;
        r_in = cr;
        g_in = cg;
        b_in = cb;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        check_vec(got, tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, zero_exp(), "idle");
        end
    endtask

    // eo: offset within this line at which a timing violation is detected (-1: none).
    task automatic drive_line(input int line, input int len, input int pw, input int eo,
                              input string tag);
        for (int off = 0; off < len; off++) begin
            exp_t e;
            logic fault, lb;
            logic [3:0] cr, cg, cb;
            fault  = (off == eo);
            lb     = (cnt >= 3);
            e      = zero_exp();
            e.fs   = (off == 0) && (line == 0);
            e.terr = fault && lb;
            if (fault) cnt = 0;
            else if (e.fs) cnt++;
            e.lck  = (cnt >= 3);
            e.vld  = lb && !fault && (line >= Y0) && (line < Y0 + H) && (off >= X0) && (off < X0 + W);
            cr = 4'($urandom);
            cg = 4'($urandom);
            cb = 4'($urandom);
            if (e.vld) begin
                e.r = cr; e.g = cg; e.b = cb;
                e.x = XW'(off - X0);
                e.y = YW'(line - Y0);
            end
            step(off < pw, line < VP, cr, cg, cb, e, tag);
        end
    endtask

    // err_line == n_lines means the violation is seen at the next frame's first edge.
    task automatic drive_frame(input int n_lines, input int fl, input int flen, input int fpw,
                               input int el, input int eo, input string tag);
        for (int l = 0; l < n_lines; l++) begin
            int len, pw, e;
            len = (l == fl) ? flen : HT;
            pw  = (l == fl) ? fpw : HP;
            e   = -1;
            if ((l == 0) && (pend_eo >= 0)) begin
                e = pend_eo;
                pend_eo = -1;
            end
            if (l == el) e = eo;
            drive_line(l, len, pw, e, tag);
        end
        if (el == n_lines) pend_eo = eo;
    endtask

    task automatic clean_frame(input string tag);
        drive_frame(VT, -1, HT, HP, -1, -1, tag);
    endtask

    initial begin
        tbl[0] = '{"clean_frame",   VT, HT,     HP,     -1,             -1};
        tbl[1] = '{"short_line",    VT, HT - 1, HP,     FAULT_LINE + 1, 0};
        tbl[2] = '{"narrow_hpulse", VT, HT,     HP - 1, FAULT_LINE,     HP - 1};
        tbl[3] = '{"wide_hpulse",   VT, HT,     HP + 1, FAULT_LINE,     HP + 1};
        tbl[4] = '{"line_timeout",  VT, HT + 1, HP,     FAULT_LINE,     HT};
        tbl[5] = '{"short_frame",   VT - 1, HT, HP,     VT - 1,         0};

        hs_raw = 1'b1; vs_raw = 1'b1; hs_pos = 1'b0; vs_pos = 1'b0;
        r_in = '0; g_in = '0; b_in = '0;
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        #1 check_vec(zero_exp(), "reset_state");
        repeat (3) @(posedge CLK);
        #1 check_vec(zero_exp(), "reset_hold");
        RST_N = 1'b1;

        idle(3);
        while (cnt < 3) clean_frame("acquire");
        clean_frame("locked_stream");

        for (int i = 0; i < 6; i++) begin
            while (cnt < 3) clean_frame("relock");
            drive_frame(tbl[i].n_lines, FAULT_LINE, tbl[i].flen, tbl[i].fpw,
                        tbl[i].err_line, tbl[i].err_off, tbl[i].name);
        end
        clean_frame("after_short_frame");
        while (cnt < 3) clean_frame("relock");

        // Asynchronous reset in the middle of a visible line while locked.
        for (int l = 0; l < FAULT_LINE + 1; l++) drive_line(l, HT, HP, -1, "pre_reset");
        drive_line(FAULT_LINE + 1, X0 + 5, HP, -1, "pre_reset");
        #2 RST_N = 1'b0;
        #1 check_vec(zero_exp(), "async_reset");
        sb.delete();
        cnt = 0;
        pend_eo = -1;
        hs_raw = 1'b1; vs_raw = 1'b1; hs_pos = 1'b0; vs_pos = 1'b0;
        repeat (2) @(posedge CLK);
        #1 check_vec(zero_exp(), "async_reset_hold");
        RST_N = 1'b1;

        idle(2);
        while (cnt < 3) clean_frame("reacquire");
        clean_frame("final_stream");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
